training_sequencer: RTL
=======================

TRAINING_SEQUENCER -- requirements
Module: training_sequencer

Interface
REQ-001 Parameter N_INPUTS, default 32: dendrite count of the sequenced neuron.
REQ-002 Parameter WIDTH, default 32: dendrite/axon/rate word width.
REQ-003 Parameter SETTLE_CYCLES, default 2: cycles the neuron datapath is given to settle after dendrites change (legal range 1..15).
REQ-004 Parameter DECAY_PERIOD, default 256: weight updates between rate decays; used only when TS_LR_DECAY_EN is defined.
REQ-005 ts_clock  in  1  sole clock; all state changes on its rising edge.
REQ-006 ts_reset  in  1  reset; synchronous and active-high.
REQ-007 ts_sampleValid / ts_sampleReady  in / out  1 / 1  sample handshake.
REQ-008 ts_sample  in  N_INPUTS x WIDTH  input vector.
REQ-009 ts_train  in  1  sampled with the sample: 1 = train, 0 = inference only.
REQ-010 ts_dendrites  out  N_INPUTS x WIDTH  registered vector driven to the neuron.
REQ-011 ts_axon  in  WIDTH  neuron output.
REQ-012 ts_resultValid / ts_resultReady  out / in  1 / 1  result handshake.
REQ-013 ts_result  out  WIDTH  captured axon value.
REQ-014 ts_gradValid / ts_gradReady  in / out  1 / 1  gradient handshake from downstream.
REQ-015 ts_grad  in  2*WIDTH  error term.
REQ-016 ts_backprop  out  2*WIDTH  registered error term driven to the backprop datapath.
REQ-017 ts_weightEnable  out  1  one-cycle pulse that commits the new weights.
REQ-018 ts_lrMul / ts_lrDiv  in  WIDTH each  base training multiplier and divisor.
REQ-019 ts_trainingMul / ts_trainingDiv  out  WIDTH each  rate driven to the datapath.
REQ-020 ts_busy  out  1  high whenever the state is not IDLE.
REQ-021 ts_updateCount  out  32  count of committed weight updates.

Function
REQ-022 FSM states: IDLE, SETTLE, RESULT, WAIT_GRAD, PRE_UPDATE, UPDATE.
REQ-023 IDLE: ts_sampleReady=1.
- On ts_sampleValid: register ts_sample into ts_dendrites and latch ts_train.
- Load the settle counter with SETTLE_CYCLES-1, then go to SETTLE.
REQ-024 SETTLE: decrement the counter; at 0, capture ts_axon into ts_result, set ts_resultValid=1 and go to RESULT.
REQ-025 RESULT: hold ts_result and ts_resultValid stable until ts_resultReady=1.
- On acceptance, clear ts_resultValid.
- Go to WAIT_GRAD if train was latched, else IDLE.
REQ-026 WAIT_GRAD: ts_gradReady=1.
- On ts_gradValid, register ts_grad into ts_backprop and go to PRE_UPDATE.
REQ-027 PRE_UPDATE lasts exactly one cycle so that the backprop datapath sees the registered ts_backprop; then go to UPDATE.
REQ-028 UPDATE lasts exactly one cycle.
- ts_weightEnable=1 during it.
- ts_updateCount increments, wrapping at 2^32-1 -> 0.
- Then go to IDLE.
REQ-029 ts_weightEnable is 1 only in UPDATE, so exactly one pulse occurs per trained sample.
REQ-030 Latency:
- Sample acceptance -> ts_resultValid is SETTLE_CYCLES cycles.
- Gradient acceptance -> ts_weightEnable is 2 cycles.
REQ-031 ts_sampleReady and ts_gradReady are never both 1.
- ts_sampleValid is ignored outside IDLE.
- ts_gradValid is ignored outside WAIT_GRAD.
REQ-032 ts_dendrites and ts_backprop hold their values from load until the next load.

Reset
REQ-033 While ts_reset=1 at a clock edge, the following are cleared:
- state -> IDLE; all valid/ready/enable outputs, ts_dendrites, ts_backprop, ts_result and ts_updateCount -> 0.
- ts_trainingMul -> ts_lrMul and ts_trainingDiv -> ts_lrDiv.
REQ-034 Reset in any state, including UPDATE, aborts the transaction without a ts_weightEnable pulse on the following cycle.

Configuration
REQ-035 With TS_LR_DECAY_EN defined:
- Every DECAY_PERIOD committed updates, ts_trainingMul shifts right by 1, floored at 1.
- ts_trainingDiv is unchanged.
REQ-036 Without TS_LR_DECAY_EN, ts_trainingMul = ts_lrMul and ts_trainingDiv = ts_lrDiv at all times, and no decay counter exists.

Structure
REQ-037 A shared package training_pkg holds:
- the FSM state enum;
- the WIDTH and N_INPUTS defaults;
- a typedef for the dendrite vector.
REQ-038 The rate-decay logic is a sub-module rate_decayer, instantiated only under TS_LR_DECAY_EN.

Verification
REQ-039 Inference, SETTLE_CYCLES=2: sample with ts_train=0, ts_axon=0x55 -> ts_resultValid 2 cycles after acceptance with ts_result=0x55; no ts_gradReady; return to IDLE.
REQ-040 Train: ts_train=1, result accepted, ts_grad=0x10 -> ts_backprop=0x10, ts_weightEnable pulse 2 cycles after grad acceptance, ts_updateCount 0 -> 1.
REQ-041 Backpressure: ts_resultReady=0 for 5 cycles -> ts_result and ts_resultValid stable throughout; a ts_gradValid pulse during those cycles is ignored.
REQ-042 Reset asserted in PRE_UPDATE -> no ts_weightEnable pulse; next cycle all outputs at reset values; ts_sampleReady=1.
REQ-043 Decay, macro on, DECAY_PERIOD=2, ts_lrMul=8 -> ts_trainingMul reads 4 after 2 updates, 2 after 4, 1 after 6, still 1 after 8.
REQ-044 Wrap: force ts_updateCount=0xFFFFFFFF, run one trained sample -> ts_updateCount=0.

Source files
------------

// File: rtl/training_pkg.sv
// Shared types and defaults for the training sequencer and its rate decayer.
package training_pkg;

   localparam int TS_WIDTH_DEF    = 32;
   localparam int TS_N_INPUTS_DEF = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_RESULT,
      ST_WAIT_GRAD,
      ST_PRE_UPDATE,
      ST_UPDATE
   } ts_state_t;

   typedef logic [TS_N_INPUTS_DEF-1:0][TS_WIDTH_DEF-1:0] dendrite_vec_t;

endpackage

// File: rtl/rate_decayer.sv
// Halves the training multiplier every DECAY_PERIOD committed weight updates,
// never going below 1. Only built when TS_LR_DECAY_EN is defined.
module rate_decayer
   import training_pkg::*;
#(
   parameter int WIDTH        = TS_WIDTH_DEF,
   parameter int DECAY_PERIOD = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             commit,
   input  logic [WIDTH-1:0] lr_mul,
   output logic [WIDTH-1:0] training_mul
);

   localparam logic [31:0] PERIOD_LOAD = 32'(DECAY_PERIOD - 1);

   logic [31:0]      period_cnt_q, period_cnt_d;
   logic [WIDTH-1:0] mul_q, mul_d;
   logic [WIDTH-1:0] mul_half;

   assign mul_half = mul_q >> 1;

   always_comb begin
      period_cnt_d = period_cnt_q;
      mul_d        = mul_q;
      if (commit) begin
         if (period_cnt_q == 32'd0) begin
            period_cnt_d = PERIOD_LOAD;
            mul_d        = (mul_half == '0) ? WIDTH'(1) : mul_half;
         end else begin
            period_cnt_d = period_cnt_q - 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         period_cnt_q <= PERIOD_LOAD;
         mul_q        <= lr_mul;
      end else begin
         period_cnt_q <= period_cnt_d;
         mul_q        <= mul_d;
      end
   end

   assign training_mul = mul_q;

endmodule

// File: rtl/training_sequencer.sv
// Sample -> settle -> result -> gradient -> weight-commit sequencer for one neuron.
// Optional learning-rate decay is enabled by defining TS_LR_DECAY_EN.
//
//   state       | meaning
//   IDLE        | ready for a sample
//   SETTLE      | dendrites driven, settle down-counter running
//   RESULT      | result held until downstream accepts it
//   WAIT_GRAD   | trained sample, waiting for the error term
//   PRE_UPDATE  | backprop register visible to the datapath for one cycle
//   UPDATE      | one-cycle weight commit
module training_sequencer
   import training_pkg::*;
#(
   parameter int N_INPUTS      = TS_N_INPUTS_DEF,
   parameter int WIDTH         = TS_WIDTH_DEF,
   parameter int SETTLE_CYCLES = 2,
   parameter int DECAY_PERIOD  = 256
) (
   input  logic                            ts_clock,
   input  logic                            ts_reset,
   input  logic                            ts_sampleValid,
   output logic                            ts_sampleReady,
   input  logic [N_INPUTS-1:0][WIDTH-1:0]  ts_sample,
   input  logic                            ts_train,
   output logic [N_INPUTS-1:0][WIDTH-1:0]  ts_dendrites,
   input  logic [WIDTH-1:0]                ts_axon,
   output logic                            ts_resultValid,
   input  logic                            ts_resultReady,
   output logic [WIDTH-1:0]                ts_result,
   input  logic                            ts_gradValid,
   output logic                            ts_gradReady,
   input  logic [2*WIDTH-1:0]              ts_grad,
   output logic [2*WIDTH-1:0]              ts_backprop,
   output logic                            ts_weightEnable,
   input  logic [WIDTH-1:0]                ts_lrMul,
   input  logic [WIDTH-1:0]                ts_lrDiv,
   output logic [WIDTH-1:0]                ts_trainingMul,
   output logic [WIDTH-1:0]                ts_trainingDiv,
   output logic                            ts_busy,
   output logic [31:0]                     ts_updateCount
);

   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("training_sequencer: SETTLE_CYCLES must be 1..15");
   end
   if (DECAY_PERIOD < 1) begin : g_bad_decay
      $error("training_sequencer: DECAY_PERIOD must be at least 1");
   end

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   ts_state_t                       state_q, state_d;
   logic [3:0]                      settle_cnt_q, settle_cnt_d;
   logic                            train_q, train_d;
   logic [N_INPUTS-1:0][WIDTH-1:0]  dendrites_q, dendrites_d;
   logic [2*WIDTH-1:0]              backprop_q, backprop_d;
   logic [WIDTH-1:0]                result_q, result_d;
   logic                            result_valid_q, result_valid_d;
   logic [31:0]                     update_count_q, update_count_d;

   always_comb begin
      state_d        = state_q;
      settle_cnt_d   = settle_cnt_q;
      train_d        = train_q;
      dendrites_d    = dendrites_q;
      backprop_d     = backprop_q;
      result_d       = result_q;
      result_valid_d = result_valid_q;
      update_count_d = update_count_q;

      unique case (state_q)
         ST_IDLE: begin
            if (ts_sampleValid) begin
               dendrites_d  = ts_sample;
               train_d      = ts_train;
               settle_cnt_d = SETTLE_LOAD;
               state_d      = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (settle_cnt_q == 4'd0) begin
               result_d       = ts_axon;
               result_valid_d = 1'b1;
               state_d        = ST_RESULT;
            end else begin
               settle_cnt_d = settle_cnt_q - 4'd1;
            end
         end
         ST_RESULT: begin
            if (ts_resultReady) begin
               result_valid_d = 1'b0;
               state_d        = train_q ? ST_WAIT_GRAD : ST_IDLE;
            end
         end
         ST_WAIT_GRAD: begin
            if (ts_gradValid) begin
               backprop_d = ts_grad;
               state_d    = ST_PRE_UPDATE;
            end
         end
         ST_PRE_UPDATE: state_d = ST_UPDATE;
         ST_UPDATE: begin
            update_count_d = update_count_q + 32'd1;
            state_d        = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ts_clock) begin
      if (ts_reset) begin
         state_q        <= ST_IDLE;
         settle_cnt_q   <= '0;
         train_q        <= 1'b0;
         dendrites_q    <= '0;
         backprop_q     <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         update_count_q <= '0;
      end else begin
         state_q        <= state_d;
         settle_cnt_q   <= settle_cnt_d;
         train_q        <= train_d;
         dendrites_q    <= dendrites_d;
         backprop_q     <= backprop_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         update_count_q <= update_count_d;
      end
   end

   // Handshake readies and the commit pulse are pure state decodes, so a reset
   // edge in any state removes them on the very next cycle.
   assign ts_sampleReady  = (state_q == ST_IDLE);
   assign ts_gradReady    = (state_q == ST_WAIT_GRAD);
   assign ts_weightEnable = (state_q == ST_UPDATE);
   assign ts_busy         = (state_q != ST_IDLE);
   assign ts_dendrites    = dendrites_q;
   assign ts_backprop     = backprop_q;
   assign ts_result       = result_q;
   assign ts_resultValid  = result_valid_q;
   assign ts_updateCount  = update_count_q;
   assign ts_trainingDiv  = ts_lrDiv;

`ifdef TS_LR_DECAY_EN
   rate_decayer #(
      .WIDTH        (WIDTH),
      .DECAY_PERIOD (DECAY_PERIOD)
   ) u_rate_decayer (
      .clk          (ts_clock),
      .rst          (ts_reset),
      .commit       (ts_weightEnable),
      .lr_mul       (ts_lrMul),
      .training_mul (ts_trainingMul)
   );
`else
   assign ts_trainingMul = ts_lrMul;
`endif

endmodule
